fetch_decode_latch: RTL and testbench

- IF/ID pipeline register between the Fetch stage (16-bit instruction memory, PC advancing by 2) and the Decode stage.
- Captures each fetched halfword with its PC.
- Assembles two-word instructions (opcode word plus 16-bit immediate word) into one decode bundle.
- Honours stall and flush from the hazard/branch logic.

---
 rtl/pipeline_pkg.sv | 23 ++
 rtl/sat_counter.sv | 21 ++
 rtl/fetch_decode_latch.sv | 138 +++++++++++++
 tb/tb_fetch_decode_latch.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: IF/ID state encoding, the NOP constant, default widths
// and the decode bundle struct that the IF/ID and ID/EX registers both carry.
package pipeline_pkg;

  localparam int DEF_INSTR_W = 16;
  localparam int DEF_PC_W    = 32;

  localparam logic [DEF_INSTR_W-1:0] DEF_NOP_WORD = 16'h0000;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_IMM = 1'b1
  } ifid_state_t;

  typedef struct packed {
    logic                   valid;
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_INSTR_W-1:0] imm;
    logic [DEF_PC_W-1:0]    pc;
    logic [DEF_PC_W-1:0]    pc_next;
  } ifid_bundle_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_decode_latch.sv
// IF/ID pipeline register: captures fetched halfwords and assembles two-word instructions.
// Optional performance counters (perf_bubbles, perf_flushes) under macro IFID_PERF_EN.
module fetch_decode_latch
  import pipeline_pkg::*;
#(
  parameter int                 INSTR_W  = DEF_INSTR_W,
  parameter int                 PC_W     = DEF_PC_W,
  parameter int                 LONG_BIT = 15,
  parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(DEF_NOP_WORD),
  parameter int                 PERF_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_valid,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_addr_in,
  input  logic [PC_W-1:0]    pc_next_in,
  input  logic               stall,
  input  logic               flush,
  output logic               valid_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic [INSTR_W-1:0] imm_out,
  output logic [PC_W-1:0]    pc_out,
  output logic [PC_W-1:0]    pc_next_out,
  output logic               imm_pending
`ifdef IFID_PERF_EN
  ,
  output logic [PERF_W-1:0]  perf_bubbles,
  output logic [PERF_W-1:0]  perf_flushes
`endif
);

  ifid_state_t        state_q, state_d;
  logic               valid_d;
  logic [INSTR_W-1:0] instr_d, imm_d;
  logic [PC_W-1:0]    pc_d, pc_next_d;
  logic [INSTR_W-1:0] hold_word_q, hold_word_d;
  logic [PC_W-1:0]    hold_pc_q, hold_pc_d;

  // NOTE: every always_comb output is defaulted first (to its current value), so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_out;
    instr_d     = instr_out;
    imm_d       = imm_out;
    pc_d        = pc_out;
    pc_next_d   = pc_next_out;
    hold_word_d = hold_word_q;
    hold_pc_d   = hold_pc_q;

    if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP_WORD;
      imm_d   = '0;
      state_d = IDLE;
    end else if (!stall) begin
      // Bubble unless a complete instruction is handed over below; PC outputs hold.
      valid_d = 1'b0;
      instr_d = NOP_WORD;
      imm_d   = '0;
      case (state_q)
        IDLE: begin
          if (fetch_valid) begin
            if (instr_in[LONG_BIT]) begin
              hold_word_d = instr_in;
              hold_pc_d   = pc_addr_in;
              state_d     = WAIT_IMM;
            end else begin
              valid_d   = 1'b1;
              instr_d   = instr_in;
              pc_d      = pc_addr_in;
              pc_next_d = pc_next_in;
            end
          end
        end
        WAIT_IMM: begin
          // The immediate word is taken verbatim; its top bit carries no meaning here.
          if (fetch_valid) begin
            valid_d   = 1'b1;
            instr_d   = hold_word_q;
            imm_d     = instr_in;
            pc_d      = hold_pc_q;
            pc_next_d = pc_next_in;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_out   <= 1'b0;
      instr_out   <= NOP_WORD;
      imm_out     <= '0;
      pc_out      <= '0;
      pc_next_out <= '0;
      hold_word_q <= '0;
      hold_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      valid_out   <= valid_d;
      instr_out   <= instr_d;
      imm_out     <= imm_d;
      pc_out      <= pc_d;
      pc_next_out <= pc_next_d;
      hold_word_q <= hold_word_d;
      hold_pc_q   <= hold_pc_d;
    end
  end

  assign imm_pending = (state_q == WAIT_IMM);

`ifdef IFID_PERF_EN
  logic bubble_inc, flush_inc;

  assign bubble_inc = !reset && !flush && !stall && !valid_d;
  assign flush_inc  = !reset && flush;

  sat_counter #(.W(PERF_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bubble_inc),
    .count (perf_bubbles)
  );

  sat_counter #(.W(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (perf_flushes)
  );
`endif

endmodule

// File: tb/tb_fetch_decode_latch.sv
// Self-checking bench for fetch_decode_latch: directed scenarios plus random traffic
// compared cycle by cycle against an instruction-level reference model.
module tb_fetch_decode_latch;

  localparam int PERF_W = 4;
  localparam int PMAX   = (1 << PERF_W) - 1;

  logic        clk = 1'b0;
  logic        reset, fetch_valid, stall, flush;
  logic [15:0] instr_in;
  logic [31:0] pc_addr_in, pc_next_in;
  logic        valid_out, imm_pending;
  logic [15:0] instr_out, imm_out;
  logic [31:0] pc_out, pc_next_out;
`ifdef IFID_PERF_EN
  logic [PERF_W-1:0] perf_bubbles, perf_flushes;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  fetch_decode_latch #(.PERF_W(PERF_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_valid (fetch_valid),
    .instr_in    (instr_in),
    .pc_addr_in  (pc_addr_in),
    .pc_next_in  (pc_next_in),
    .stall       (stall),
    .flush       (flush),
    .valid_out   (valid_out),
    .instr_out   (instr_out),
    .imm_out     (imm_out),
    .pc_out      (pc_out),
    .pc_next_out (pc_next_out),
    .imm_pending (imm_pending)
`ifdef IFID_PERF_EN
    ,
    .perf_bubbles(perf_bubbles),
    .perf_flushes(perf_flushes)
`endif
  );

  // Reference model: what Decode should see, plus the half-assembled instruction.
  bit          exp_valid;
  logic [15:0] exp_instr, exp_imm;
  logic [31:0] exp_pc, exp_pc_next;
  bit          have_opcode;
  logic [15:0] opcode_word;
  logic [31:0] opcode_pc;
  int          exp_bubbles, exp_flushes;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic show_bubble();
    exp_valid = 0;
    exp_instr = 16'h0000;
    exp_imm   = 16'h0000;
  endtask

  task automatic model_step();
    if (reset) begin
      show_bubble();
      exp_pc = 0; exp_pc_next = 0;
      have_opcode = 0; opcode_word = 0; opcode_pc = 0;
      exp_bubbles = 0; exp_flushes = 0;
    end else if (flush) begin
      show_bubble();
      have_opcode = 0;
      exp_flushes = (exp_flushes < PMAX) ? exp_flushes + 1 : PMAX;
    end else if (stall) begin
      // nothing consumed, nothing changes
    end else if (!fetch_valid) begin
      show_bubble();
      exp_bubbles = (exp_bubbles < PMAX) ? exp_bubbles + 1 : PMAX;
    end else if (have_opcode) begin
      exp_valid = 1; exp_instr = opcode_word; exp_imm = instr_in;
      exp_pc = opcode_pc; exp_pc_next = pc_next_in;
      have_opcode = 0;
    end else if (instr_in[15]) begin
      opcode_word = instr_in; opcode_pc = pc_addr_in; have_opcode = 1;
      show_bubble();
      exp_bubbles = (exp_bubbles < PMAX) ? exp_bubbles + 1 : PMAX;
    end else begin
      exp_valid = 1; exp_instr = instr_in; exp_imm = 0;
      exp_pc = pc_addr_in; exp_pc_next = pc_next_in;
    end
  endtask

  // Drive one cycle's inputs at negedge, let the edge pass, then compare everything.
  task automatic step(input bit r, input bit fl, input bit st, input bit fv,
                      input logic [15:0] w, input logic [31:0] pc);
    @(negedge clk);
    reset = r; flush = fl; stall = st; fetch_valid = fv;
    instr_in = w; pc_addr_in = pc; pc_next_in = pc + 32'd2;
    @(posedge clk);
    model_step();
    #1;
    check("valid_out",   {31'b0, valid_out},   {31'b0, exp_valid});
    check("instr_out",   {16'b0, instr_out},   {16'b0, exp_instr});
    check("imm_out",     {16'b0, imm_out},     {16'b0, exp_imm});
    check("pc_out",      pc_out,               exp_pc);
    check("pc_next_out", pc_next_out,          exp_pc_next);
    check("imm_pending", {31'b0, imm_pending}, {31'b0, have_opcode});
`ifdef IFID_PERF_EN
    check("perf_bubbles", 32'(perf_bubbles), 32'(exp_bubbles));
    check("perf_flushes", 32'(perf_flushes), 32'(exp_flushes));
`endif
  endtask

  initial begin
    logic [31:0] pc;
    reset = 1; flush = 0; stall = 0; fetch_valid = 0;
    instr_in = 0; pc_addr_in = 0; pc_next_in = 0;

    // Reset state
    step(1, 0, 0, 0, 16'h0000, 0);
    step(1, 0, 0, 0, 16'h0000, 0);
    check("rst_instr", {16'b0, instr_out}, 32'h0000);
    check("rst_pc_next", pc_next_out, 32'd0);

    // One-word instruction, 1-cycle latency
    step(0, 0, 0, 1, 16'h1234, 32);
    check("short_valid", {31'b0, valid_out}, 32'd1);
    check("short_instr", {16'b0, instr_out}, 32'h1234);
    check("short_pc", pc_out, 32'd32);
    check("short_pcn", pc_next_out, 32'd34);

    // Two-word instruction
    step(0, 0, 0, 1, 16'h8A01, 40);
    check("long_bubble", {31'b0, valid_out}, 32'd0);
    check("long_pending", {31'b0, imm_pending}, 32'd1);
    step(0, 0, 0, 1, 16'h00FF, 42);
    check("long_instr", {16'b0, instr_out}, 32'h8A01);
    check("long_imm", {16'b0, imm_out}, 32'h00FF);
    check("long_pc", pc_out, 32'd40);
    check("long_pcn", pc_next_out, 32'd44);

    // Stall in the middle of assembly
    step(0, 0, 0, 1, 16'h8A01, 50);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, (i % 2) ? 16'hFFFF : 16'h5555, 52);
    check("stall_pending", {31'b0, imm_pending}, 32'd1);
    step(0, 0, 0, 1, 16'h0042, 52);
    check("stall_instr", {16'b0, instr_out}, 32'h8A01);
    check("stall_imm", {16'b0, imm_out}, 32'h0042);

    // Flush beats stall and drops the half-assembled instruction
    step(0, 0, 0, 1, 16'h8A01, 60);
    step(0, 1, 1, 1, 16'h00AA, 62);
    check("flush_valid", {31'b0, valid_out}, 32'd0);
    check("flush_pending", {31'b0, imm_pending}, 32'd0);
    step(0, 0, 0, 1, 16'h1111, 62);
    check("after_flush", {16'b0, instr_out}, 32'h1111);

    // Reset mid-assembly loses the held word
    step(0, 0, 0, 1, 16'hC0DE, 70);
    step(1, 0, 0, 1, 16'h0001, 72);
    step(0, 0, 0, 1, 16'h0002, 80);

`ifdef IFID_PERF_EN
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0);
    check("perf_bub_sat", 32'(perf_bubbles), 32'd15);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    check("perf_fl_3", 32'(perf_flushes), 32'd3);
    step(1, 0, 0, 0, 0, 0);
    check("perf_clr", 32'(perf_bubbles) + 32'(perf_flushes), 32'd0);
`endif

    // Random traffic; roughly half the words carry the long-instruction bit
    pc = 32'h100;
    for (int i = 0; i < 600; i++) begin
      bit r, fl, st, fv;
      r  = ($urandom_range(0, 99) < 2);
      fl = ($urandom_range(0, 99) < 6);
      st = ($urandom_range(0, 99) < 15);
      fv = ($urandom_range(0, 99) < 75);
      step(r, fl, st, fv, 16'($urandom), pc);
      if (fl || r) pc = {$urandom_range(0, 32'hFFFF), 1'b0};
      else if (fv && !st) pc = pc + 2;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
